// File: rtl/kmeans_pkg.sv
// Shared sizes and controller state encoding for the k-means iteration controller.
package kmeans_pkg;

  localparam int K_DEF      = 8;
  localparam int D_DEF      = 4;
  localparam int W_DEF      = 8;
  localparam int ADDR_W_DEF = 8;
  localparam int ITER_W_DEF = 8;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [6:0] {
    S_IDLE   = 7'b0000001,
    S_LOAD   = 7'b0000010,
    S_CLEAR  = 7'b0000100,
    S_STREAM = 7'b0001000,
    S_MEAN   = 7'b0010000,
    S_CHECK  = 7'b0100000,
    S_DONE   = 7'b1000000
  } state_e;

endpackage

// File: rtl/kmeans_skid_fifo.sv
// Two-entry valid/ready buffer between the point RAM read port and the assignment unit.
module kmeans_skid_fifo
  import kmeans_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    count
);

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    cnt_q;
  logic          push;
  logic          pop;

  assign in_ready  = (cnt_q != 2'(FIFO_DEPTH));
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = cnt_q;
  // Payload is forced to zero while empty so nothing stale leaks after reset/flush.
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/kmeans_iter_ctrl.sv
// Run sequencer for k-means: load, then repeated clear/stream/mean/check passes until
// the centroids settle within tolerance or the iteration limit is reached.
module kmeans_iter_ctrl
  import kmeans_pkg::*;
#(
  parameter int K      = K_DEF,
  parameter int D      = D_DEF,
  parameter int W      = W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ITER_W = ITER_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   num_points,
  input  logic [ITER_W-1:0]   max_iter,
  input  logic [W-1:0]        conv_thresh,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [D*W-1:0]      mem_rd_data,
  output logic                asg_in_valid,
  input  logic                asg_in_ready,
  output logic [D*W-1:0]      asg_point,
  input  logic                asg_out_valid,
  output logic                asg_flush,
  output logic                acc_load,
  output logic                acc_clear,
  output logic                acc_valid,
  output logic                acc_compute_mean,
  input  logic [K*D*W-1:0]    centroid_flat,
  output logic                busy,
  output logic                done,
  output logic                converged,
  output logic [ITER_W-1:0]   iter_count
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   num_q;
  logic [ITER_W-1:0]   max_iter_q;
  logic [W-1:0]        thresh_q;
  logic [ADDR_W-1:0]   issued_q;
  logic [ADDR_W-1:0]   returned_q;
  logic                rd_vld_q;
  logic [ITER_W-1:0]   iter_q;
  logic                conv_q;
  logic [K*D*W-1:0]    old_c_q;
  logic [ITER_W-1:0]   iter_inc;
  logic                conv_hit;
  logic                start_ok;
  logic                fifo_in_ready;
  logic [1:0]          fifo_count;
  logic                fifo_pop;
  logic [1:0]          occ;

  // True when every coordinate moved by no more than th (magnitude taken in W+1 bits).
  function automatic logic fields_converged(input logic [K*D*W-1:0] cur,
                                            input logic [K*D*W-1:0] prev,
                                            input logic [W-1:0]     th);
    logic signed [W:0] diff;
    logic        [W:0] mag;
    logic              ok;
    ok = 1'b1;
    for (int i = 0; i < K*D; i++) begin
      diff = $signed({cur[i*W+W-1], cur[i*W +: W]}) - $signed({prev[i*W+W-1], prev[i*W +: W]});
      mag  = diff[W] ? $unsigned(-diff) : $unsigned(diff);
      ok   = ok & (mag <= {1'b0, th});
    end
    return ok;
  endfunction

  assign busy        = (state_q != S_IDLE);
  assign asg_flush   = abort & busy;
  assign start_ok    = (state_q == S_IDLE) & start & ~abort;
  assign iter_inc    = iter_q + ITER_W'(1);
  assign conv_hit    = fields_converged(centroid_flat, old_c_q, thresh_q);
  assign mem_rd_addr = issued_q;
  assign converged   = conv_q;
  assign iter_count  = iter_q;
  assign fifo_pop    = asg_in_valid & asg_in_ready;
  // Reads in flight plus entries still buffered after this cycle's hand-off.
  assign occ         = 2'(rd_vld_q) + fifo_count - 2'(fifo_pop);

  kmeans_skid_fifo #(
    .DW (D*W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (asg_flush),
    .in_valid  (rd_vld_q),
    .in_ready  (fifo_in_ready),
    .in_data   (mem_rd_data),
    .out_valid (asg_in_valid),
    .out_ready (asg_in_ready),
    .out_data  (asg_point),
    .count     (fifo_count)
  );

  always_comb begin
    state_d          = state_q;
    mem_rd_en        = 1'b0;
    acc_load         = 1'b0;
    acc_clear        = 1'b0;
    acc_valid        = 1'b0;
    acc_compute_mean = 1'b0;
    done             = 1'b0;
    if (abort && busy) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ok) state_d = (num_points == '0) ? S_DONE : S_LOAD;
        end
        S_LOAD: begin
          acc_load = 1'b1;
          state_d  = S_CLEAR;
        end
        S_CLEAR: begin
          acc_clear = 1'b1;
          state_d   = S_STREAM;
        end
        S_STREAM: begin
          mem_rd_en = (issued_q != num_q) && (occ < 2'd2) && fifo_in_ready;
          acc_valid = asg_out_valid && (returned_q != num_q);
          if (returned_q == num_q) state_d = S_MEAN;
        end
        S_MEAN: begin
          acc_compute_mean = 1'b1;
          state_d          = S_CHECK;
        end
        S_CHECK: begin
          state_d = (conv_hit || (iter_inc == max_iter_q)) ? S_DONE : S_CLEAR;
        end
        S_DONE: begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      num_q      <= '0;
      max_iter_q <= '0;
      thresh_q   <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      rd_vld_q   <= 1'b0;
      iter_q     <= '0;
      conv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= mem_rd_en;
      if (start_ok) begin
        num_q      <= num_points;
        max_iter_q <= (max_iter == '0) ? ITER_W'(1) : max_iter;
        thresh_q   <= conv_thresh;
        iter_q     <= '0;
        conv_q     <= 1'b0;
      end
      if (state_q == S_CLEAR) begin
        issued_q   <= '0;
        returned_q <= '0;
      end
      if (mem_rd_en) issued_q   <= issued_q + 1'b1;
      if (acc_valid) returned_q <= returned_q + 1'b1;
      if (state_q == S_CHECK && !abort) begin
        iter_q <= iter_inc;
        if (conv_hit) conv_q <= 1'b1;
      end
    end
  end

  // Pre-divide centroid snapshot, compared against the post-divide bus one cycle later.
  always_ff @(posedge clk) begin
    if (state_q == S_MEAN) old_c_q <= centroid_flat;
  end

endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// Directed bench: point RAM, 3-cycle assignment unit and scripted accumulator models around the controller.
module tb_kmeans_iter_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, abort;
  logic [7:0]   num_points, max_iter, conv_thresh;
  logic         mem_rd_en;
  logic [7:0]   mem_rd_addr;
  logic [31:0]  ram_q;
  logic         asg_in_valid, asg_in_ready, asg_out_valid, asg_flush;
  logic [31:0]  asg_point;
  logic         acc_load, acc_clear, acc_valid, acc_compute_mean;
  logic [255:0] cent, init_c;
  logic         busy, done, converged;
  logic [7:0]   iter_count;
  logic [2:0]   apipe;
  logic         tog, rdy_toggle;
  logic signed [7:0] dtab [16];
  int           step;

  int vectors = 0, miscompares = 0;
  int mcyc = 0, n_rd = 0, n_dl = 0, n_load = 0, n_clear = 0, n_av = 0, n_mean = 0, n_done = 0;
  int bad_addr = 0, bad_pt = 0, overlap = 0, occ_viol = 0;
  int exp_addr = 0, dl_idx = 0, first_cyc = 0, last_cyc = 0, tb_buf = 0, tb_infl = 0;
  int s_rd, s_dl, s_load, s_clear, s_av, s_mean, s_done, av_at_abort;
  bit seen;

  always #5 clk = ~clk;

  kmeans_iter_ctrl dut (
    .clk (clk), .rst_n (rst_n), .start (start), .abort (abort),
    .num_points (num_points), .max_iter (max_iter), .conv_thresh (conv_thresh),
    .mem_rd_en (mem_rd_en), .mem_rd_addr (mem_rd_addr), .mem_rd_data (ram_q),
    .asg_in_valid (asg_in_valid), .asg_in_ready (asg_in_ready), .asg_point (asg_point),
    .asg_out_valid (asg_out_valid), .asg_flush (asg_flush),
    .acc_load (acc_load), .acc_clear (acc_clear), .acc_valid (acc_valid),
    .acc_compute_mean (acc_compute_mean), .centroid_flat (cent),
    .busy (busy), .done (done), .converged (converged), .iter_count (iter_count)
  );

  function automatic logic [31:0] pt(input logic [7:0] a);
    return {a + 8'd3, a + 8'd2, a + 8'd1, a ^ 8'h5A};
  endfunction

  always @(posedge clk) if (mem_rd_en) ram_q <= pt(mem_rd_addr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      apipe <= '0;
      tog   <= 1'b0;
    end else begin
      apipe <= {apipe[1:0], asg_in_valid & asg_in_ready};
      tog   <= ~tog;
    end
  end
  assign asg_out_valid = apipe[2];
  assign asg_in_ready  = rdy_toggle ? tog : 1'b1;

  // Accumulator: load restores init_c, each divide moves the last field by the next table step.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cent <= '0;
      step <= 0;
    end else if (acc_load) begin
      cent <= init_c;
      step <= 0;
    end else if (acc_compute_mean) begin
      cent[255:248] <= cent[255:248] + 8'(dtab[step]);
      step          <= step + 1;
    end
  end

  always @(negedge clk) begin
    mcyc <= mcyc + 1;
    if (mem_rd_en) begin
      n_rd <= n_rd + 1;
      if (mem_rd_addr !== 8'(exp_addr)) bad_addr <= bad_addr + 1;
      if (exp_addr == 0) first_cyc <= mcyc;
      last_cyc <= mcyc;
      exp_addr <= exp_addr + 1;
    end
    if (acc_clear) begin
      exp_addr <= 0;
      dl_idx   <= 0;
    end
    if (asg_in_valid && asg_in_ready) begin
      n_dl <= n_dl + 1;
      if (asg_point !== pt(8'(dl_idx))) bad_pt <= bad_pt + 1;
      dl_idx <= dl_idx + 1;
    end
    if (acc_load)         n_load  <= n_load + 1;
    if (acc_clear)        n_clear <= n_clear + 1;
    if (acc_valid)        n_av    <= n_av + 1;
    if (acc_compute_mean) n_mean  <= n_mean + 1;
    if (done)             n_done  <= n_done + 1;
    if ((int'(acc_load) + int'(acc_clear) + int'(acc_valid) + int'(acc_compute_mean)) > 1)
      overlap <= overlap + 1;
    if (!rst_n || asg_flush) begin
      tb_buf  <= 0;
      tb_infl <= 0;
    end else begin
      if (mem_rd_en && (tb_infl + tb_buf - int'(asg_in_valid && asg_in_ready)) > 1)
        occ_viol <= occ_viol + 1;
      if (tb_buf > 2 || (asg_in_valid !== (tb_buf != 0))) occ_viol <= occ_viol + 1;
      tb_buf  <= tb_buf + tb_infl - int'(asg_in_valid && asg_in_ready);
      tb_infl <= int'(mem_rd_en);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_rd = n_rd; s_dl = n_dl; s_load = n_load; s_clear = n_clear;
    s_av = n_av; s_mean = n_mean; s_done = n_done;
  endtask

  task automatic start_run(input int n, input int mi, input int th);
    num_points = 8'(n); max_iter = 8'(mi); conv_thresh = 8'(th); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      if (done === 1'b1) got = 1'b1;
      else tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rdy_toggle = 1'b0;
    num_points = '0; max_iter = '0; conv_thresh = '0; init_c = '0;
    for (int i = 0; i < 16; i++) dtab[i] = 8'sd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {busy, done, converged, iter_count, mem_rd_en, mem_rd_addr, asg_in_valid,
                       asg_flush, acc_load, acc_clear, acc_valid, acc_compute_mean}, 64'd0);
    chk("reset_point", asg_point, 64'd0);
    rst_n = 1'b1;
    tick();

    // abort together with start in idle: no run
    abort = 1'b1; num_points = 8'd4;
    start_run(4, 1, 0);
    abort = 1'b0;
    chk("idle_abort_start", busy, 64'd0);

    // Test 1: fixed centroids, full-rate stream of 4 points
    init_c = {32{8'h11}};
    snap();
    start_run(4, 4, 0);
    wait_done(200, seen);
    chk("t1_done", seen, 64'd1);
    chk("t1_iter", iter_count, 64'd1);
    chk("t1_conv", converged, 64'd1);
    tick();
    chk("t1_reads", n_rd - s_rd, 64'd4);
    chk("t1_rd_span", last_cyc - first_cyc, 64'd3);
    chk("t1_acc_valid", n_av - s_av, 64'd4);
    chk("t1_mean", n_mean - s_mean, 64'd1);
    chk("t1_load_clear", {32'(n_load - s_load), 32'(n_clear - s_clear)}, {32'd1, 32'd1});
    chk("t1_done_cycles", n_done - s_done, 64'd1);
    chk("t1_idle", busy, 64'd0);

    // Test 2: ready toggles, every point delivered once and in order
    rdy_toggle = 1'b1;
    snap();
    start_run(8, 1, 0);
    wait_done(400, seen);
    chk("t2_done", seen, 64'd1);
    chk("t2_conv", converged, 64'd1);
    tick();
    rdy_toggle = 1'b0;
    chk("t2_delivered", n_dl - s_dl, 64'd8);
    chk("t2_acc_valid", n_av - s_av, 64'd8);
    chk("t2_reads", n_rd - s_rd, 64'd8);
    chk("t2_occupancy", occ_viol, 64'd0);
    chk("t2_order", bad_pt, 64'd0);

    // Test 3: last field moves +3 per pass, tolerance 2, limit 5; a start mid-run is ignored
    init_c = '0;
    for (int i = 0; i < 16; i++) dtab[i] = 8'sd3;
    snap();
    start_run(2, 5, 2);
    repeat (10) tick();
    start_run(0, 1, 0);
    chk("t3_busy_start", busy, 64'd1);
    wait_done(1000, seen);
    chk("t3_done", seen, 64'd1);
    chk("t3_iter", iter_count, 64'd5);
    chk("t3_conv", converged, 64'd0);
    tick();
    chk("t3_mean", n_mean - s_mean, 64'd5);
    chk("t3_acc_valid", n_av - s_av, 64'd10);
    chk("t3_done_cycles", n_done - s_done, 64'd1);

    // max_iter 0 behaves as a single pass
    snap();
    start_run(2, 0, 2);
    wait_done(300, seen);
    chk("t3b_done", seen, 64'd1);
    chk("t3b_iter", iter_count, 64'd1);
    chk("t3b_conv", converged, 64'd0);
    tick();

    // Test 4: moves of -5,-3,-1 with tolerance 1 settle on pass 3
    init_c = '0;
    init_c[255:248] = 8'd10;
    dtab[0] = -8'sd5; dtab[1] = -8'sd3;
    for (int i = 2; i < 16; i++) dtab[i] = -8'sd1;
    snap();
    start_run(3, 10, 1);
    wait_done(1000, seen);
    chk("t4_done", seen, 64'd1);
    chk("t4_iter", iter_count, 64'd3);
    chk("t4_conv", converged, 64'd1);
    tick();
    chk("t4_mean", n_mean - s_mean, 64'd3);

    // Test 5: abort in the middle of streaming, then a clean rerun
    init_c = {32{8'h22}};
    for (int i = 0; i < 16; i++) dtab[i] = 8'sd0;
    snap();
    start_run(20, 4, 0);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick();
      if (n_rd - s_rd >= 5) seen = 1'b1;
    end
    chk("t5_streaming", seen, 64'd1);
    abort = 1'b1;
    #1;
    chk("t5_flush", asg_flush, 64'd1);
    av_at_abort = n_av;
    tick();
    abort = 1'b0;
    #1;
    chk("t5_idle", busy, 64'd0);
    chk("t5_flush_pulse", asg_flush, 64'd0);
    chk("t5_buffer_empty", asg_in_valid, 64'd0);
    repeat (6) tick();
    chk("t5_no_done", n_done - s_done, 64'd0);
    chk("t5_late_results", n_av - av_at_abort, 64'd0);
    chk("t5_iter_kept", iter_count, 64'd0);
    snap();
    start_run(4, 2, 0);
    wait_done(200, seen);
    chk("t5_rerun_done", seen, 64'd1);
    chk("t5_rerun_conv", {converged, iter_count}, {1'b1, 8'd1});
    tick();
    chk("t5_rerun_reads", n_rd - s_rd, 64'd4);
    chk("t5_rerun_delivered", n_dl - s_dl, 64'd4);
    chk("t5_addr_order", bad_addr, 64'd0);
    chk("t5_point_order", bad_pt, 64'd0);

    // Test 6: zero points finishes without touching the accumulator
    snap();
    start_run(0, 3, 0);
    chk("t6_done", {done, busy}, {1'b1, 1'b1});
    tick();
    chk("t6_done_drop", {done, busy}, 64'd0);
    chk("t6_no_strobes", (n_load - s_load) + (n_clear - s_clear) + (n_av - s_av) + (n_mean - s_mean), 64'd0);
    chk("t6_done_cycles", n_done - s_done, 64'd1);
    chk("t6_status", {converged, iter_count}, 64'd0);

    // reset asserted mid-run clears every output at once
    start_run(10, 3, 0);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctrl", {busy, done, converged, iter_count, mem_rd_en, mem_rd_addr, asg_in_valid,
                         asg_flush, acc_load, acc_clear, acc_valid, acc_compute_mean}, 64'd0);
    chk("rst_mid_point", asg_point, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_release_idle", busy, 64'd0);
    chk("strobe_overlap", overlap, 64'd0);
    chk("occupancy_total", occ_viol, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
